// File: rtl/regfile_sb.sv
// Register file with write-through read ports, per-register busy scoreboard
// and an arbitrated debug access port with a starvation guard.
module regfile_sb #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned DBG_STARVE = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr_i,
    output logic [NUM_RD*DATA_W-1:0]   rdata_o,
    output logic [NUM_RD-1:0]          rbusy_o,
    input  logic                       we_i,
    input  logic [ADDR_W-1:0]          waddr_i,
    input  logic [DATA_W-1:0]          wdata_i,
    input  logic                       issue_i,
    input  logic [ADDR_W-1:0]          issue_addr_i,
    output logic                       wr_stall_o,
    input  logic                       dbg_req_i,
    input  logic                       dbg_we_i,
    input  logic [ADDR_W-1:0]          dbg_addr_i,
    input  logic [DATA_W-1:0]          dbg_wdata_i,
    output logic                       dbg_busy_o,
    output logic                       dbg_valid_o,
    output logic [DATA_W-1:0]          dbg_rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = (DBG_STARVE < 1) ? 1 : $clog2(DBG_STARVE + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        RESP = 2'd2
    } dbg_state_e;

    dbg_state_e              state_q;
    dbg_state_e              state_d;

    logic [DATA_W-1:0]       regs_q [DEPTH];
    logic [DEPTH-1:0]        busy_q;
    logic [DEPTH-1:0]        busy_d;
    logic [CNT_W-1:0]        cnt_q;

    logic                    lat_we_q;
    logic [ADDR_W-1:0]       lat_addr_q;
    logic [DATA_W-1:0]       lat_wdata_q;
    logic [DATA_W-1:0]       dbg_rdata_q;

    logic                    dbg_do_c;
    logic                    dbg_latch_c;
    logic                    cnt_inc_c;
    logic                    core_wr_c;

    // Debug FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Debug FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (dbg_req_i) state_d = ARB;
            ARB:     if (dbg_do_c)  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Debug FSM: outputs; the core write is only preempted once the counter saturates
    always_comb begin
        wr_stall_o  = 1'b0;
        dbg_do_c    = 1'b0;
        dbg_latch_c = 1'b0;
        cnt_inc_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (dbg_req_i) dbg_latch_c = 1'b1;
            end
            ARB: begin
                if (!we_i) begin
                    dbg_do_c = 1'b1;
                end else if (cnt_q == CNT_W'(DBG_STARVE)) begin
                    wr_stall_o = 1'b1;
                    dbg_do_c   = 1'b1;
                end else begin
                    cnt_inc_c = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign dbg_busy_o  = (state_q != IDLE);
    assign dbg_valid_o = (state_q == RESP);
    assign dbg_rdata_o = dbg_rdata_q;

    assign core_wr_c = we_i && !wr_stall_o && (waddr_i != '0);

    // Starvation counter and latched debug request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
        end else begin
            if (dbg_latch_c) begin
                cnt_q       <= '0;
                lat_we_q    <= dbg_we_i;
                lat_addr_q  <= dbg_addr_i;
                lat_wdata_q <= dbg_wdata_i;
            end else if (cnt_inc_c) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Debug read data capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbg_rdata_q <= '0;
        end else if (dbg_do_c && !lat_we_q) begin
            dbg_rdata_q <= regs_q[lat_addr_q];
        end
    end

    // Register storage; core and debug writes never coincide (debug waits or stalls the core)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (core_wr_c) begin
                regs_q[waddr_i] <= wdata_i;
            end
            if (dbg_do_c && lat_we_q && (lat_addr_q != '0)) begin
                regs_q[lat_addr_q] <= lat_wdata_q;
            end
        end
    end

    // Scoreboard: writeback clears, issue sets, set wins on collision
    always_comb begin
        busy_d = busy_q;
        if (core_wr_c) begin
            busy_d[waddr_i] = 1'b0;
        end
        if (issue_i && (issue_addr_i != '0)) begin
            busy_d[issue_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Read ports with write-through bypass of the accepted core write
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;
        logic              rb;

        assign ra = raddr_i[k*ADDR_W +: ADDR_W];

        always_comb begin
            rd = '0;
            rb = 1'b0;
            if (!rst && (ra != '0)) begin
                rd = (core_wr_c && (waddr_i == ra)) ? wdata_i : regs_q[ra];
                rb = busy_q[ra];
            end
        end

        assign rdata_o[k*DATA_W +: DATA_W] = rd;
        assign rbusy_o[k]                  = rb;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized scoreboard bench for regfile_sb against a behavioural model.
module tb_regfile_sb;

    localparam int STARVE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  raddr_i;
    logic [63:0] rdata_o;
    logic [1:0]  rbusy_o;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic        issue_i;
    logic [4:0]  issue_addr_i;
    logic        wr_stall_o;
    logic        dbg_req_i;
    logic        dbg_we_i;
    logic [4:0]  dbg_addr_i;
    logic [31:0] dbg_wdata_i;
    logic        dbg_busy_o;
    logic        dbg_valid_o;
    logic [31:0] dbg_rdata_o;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .DBG_STARVE(STARVE)) dut (
        .clk(clk), .rst(rst),
        .raddr_i(raddr_i), .rdata_o(rdata_o), .rbusy_o(rbusy_o),
        .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .issue_i(issue_i), .issue_addr_i(issue_addr_i),
        .wr_stall_o(wr_stall_o),
        .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
        .dbg_wdata_i(dbg_wdata_i), .dbg_busy_o(dbg_busy_o),
        .dbg_valid_o(dbg_valid_o), .dbg_rdata_o(dbg_rdata_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [1:0]  rb;
        logic        stall;
        logic        dbusy;
        logic        dvalid;
        logic        in_rst;
    } comb_t;

    typedef struct {
        logic        is_rd;
        logic [31:0] data;
    } dbg_t;

    comb_t comb_q[$];
    dbg_t  dbg_q[$];

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] m_reg  [32];
    logic        m_busy [32];
    int          phase;     // 0 idle, 1 waiting for the port, 2 responding
    int          blocked;
    logic        l_we;
    logic [4:0]  l_addr;
    logic [31:0] l_wd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
        phase   = 0;
        blocked = 0;
        dbg_q.delete();
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input logic wr, input logic [4:0] wa,
                                           input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (wr && wa == a) return wd;
        return m_reg[a];
    endfunction

    // One clock of stimulus: drive, predict combinational outputs, then advance the model
    task automatic cyc(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic iss, input logic [4:0] ia,
                       input logic req, input logic dwe, input logic [4:0] da, input logic [31:0] dwd,
                       input logic [4:0] ra0, input logic [4:0] ra1);
        comb_t e;
        logic  stall;
        logic  core_wr;
        rst = r; we_i = we; waddr_i = wa; wdata_i = wd;
        issue_i = iss; issue_addr_i = ia;
        dbg_req_i = req; dbg_we_i = dwe; dbg_addr_i = da; dbg_wdata_i = dwd;
        raddr_i = {ra1, ra0};
        if (r) model_clear();
        stall   = !r && phase == 1 && we && blocked == STARVE;
        core_wr = !r && we && !stall && wa != 5'd0;
        e.rd0    = r ? 32'd0 : exp_rd(ra0, core_wr, wa, wd);
        e.rd1    = r ? 32'd0 : exp_rd(ra1, core_wr, wa, wd);
        e.rb[0]  = (r || ra0 == 5'd0) ? 1'b0 : m_busy[ra0];
        e.rb[1]  = (r || ra1 == 5'd0) ? 1'b0 : m_busy[ra1];
        e.stall  = stall;
        e.dbusy  = phase != 0;
        e.dvalid = phase == 2;
        e.in_rst = r;
        comb_q.push_back(e);
        @(posedge clk);
        if (!r) begin
            case (phase)
                0: if (req) begin
                    l_we = dwe; l_addr = da; l_wd = dwd; blocked = 0; phase = 1;
                end
                1: if (!we || blocked == STARVE) begin
                    if (l_we) begin
                        if (l_addr != 5'd0) m_reg[l_addr] = l_wd;
                        dbg_q.push_back('{is_rd: 1'b0, data: 32'd0});
                    end else begin
                        dbg_q.push_back('{is_rd: 1'b1, data: m_reg[l_addr]});
                    end
                    phase = 2;
                end else begin
                    blocked++;
                end
                default: phase = 0;
            endcase
            if (core_wr) begin
                m_reg[wa]  = wd;
                m_busy[wa] = 1'b0;
            end
            if (iss && ia != 5'd0) m_busy[ia] = 1'b1;
        end
        #1;
    endtask

    task automatic idle(input logic [4:0] ra0, input logic [4:0] ra1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ra0, ra1);
    endtask

    // Monitor: compares every cycle's outputs and pops debug responses on dbg_valid_o
    always @(negedge clk) begin
        comb_t e;
        dbg_t  d;
        if (comb_q.size() > 0) begin
            e = comb_q.pop_front();
            chk("rdata0", rdata_o[31:0], e.rd0);
            chk("rdata1", rdata_o[63:32], e.rd1);
            chk("rbusy", 32'(rbusy_o), 32'(e.rb));
            chk("wr_stall", 32'(wr_stall_o), 32'(e.stall));
            chk("dbg_busy", 32'(dbg_busy_o), 32'(e.dbusy));
            chk("dbg_valid", 32'(dbg_valid_o), 32'(e.dvalid));
            if (e.in_rst) chk("dbg_rdata_rst", dbg_rdata_o, 32'd0);
            if (dbg_valid_o) begin
                if (dbg_q.size() == 0) begin
                    chk("dbg_unexpected_resp", 32'(dbg_q.size()), 32'd1);
                end else begin
                    d = dbg_q.pop_front();
                    if (d.is_rd) chk("dbg_rdata", dbg_rdata_o, d.data);
                end
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1; we_i = 0; waddr_i = 0; wdata_i = 0; issue_i = 0; issue_addr_i = 0;
        dbg_req_i = 0; dbg_we_i = 0; dbg_addr_i = 0; dbg_wdata_i = 0; raddr_i = 0;
        model_clear();
        @(posedge clk);
        #1;
        cyc(1, 1, 5'd5, 32'hFFFF_FFFF, 1, 5'd5, 1, 0, 5'd5, 0, 5'd5, 5'd0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd1, 5'd2);

        // Basic write/read and x0
        cyc(0, 1, 5'd5, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 5'd1, 5'd2);
        idle(5'd5, 5'd5);
        cyc(0, 1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 5'd0, 5'd5);
        idle(5'd0, 5'd0);

        // Same-cycle bypass
        cyc(0, 1, 5'd7, 32'hA5A5_A5A5, 0, 0, 0, 0, 0, 0, 5'd7, 5'd6);
        idle(5'd7, 5'd6);

        // Scoreboard set / collision / clear
        cyc(0, 0, 0, 0, 1, 5'd9, 0, 0, 0, 0, 5'd9, 5'd9);
        idle(5'd9, 5'd0);
        cyc(0, 1, 5'd9, 32'h99, 1, 5'd9, 0, 0, 0, 0, 5'd9, 5'd9);
        idle(5'd9, 5'd9);
        cyc(0, 1, 5'd9, 32'h9A, 0, 0, 0, 0, 0, 0, 5'd9, 5'd0);
        idle(5'd9, 5'd9);

        // Debug read with core idle
        cyc(0, 1, 5'd3, 32'h55, 0, 0, 0, 0, 0, 0, 5'd3, 5'd0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 5'd3, 0, 5'd3, 5'd0);
        idle(5'd3, 5'd0);
        idle(5'd3, 5'd0);
        idle(5'd3, 5'd0);

        // Starvation: core writes every cycle, debug write preempts after STARVE blocked cycles
        cyc(0, 1, 5'd10, 32'h100, 0, 0, 1, 1, 5'd4, 32'hDEAD, 5'd10, 5'd4);
        for (int i = 1; i < 8; i++) cyc(0, 1, 5'd10, 32'h100 + 32'(i), 0, 0, 0, 0, 0, 0, 5'd10, 5'd4);
        idle(5'd4, 5'd10);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 5'd4, 0, 5'd4, 5'd0);
        idle(5'd4, 5'd0);
        idle(5'd4, 5'd0);

        // Reset while a debug access is waiting
        cyc(0, 0, 0, 0, 1, 5'd12, 0, 0, 0, 0, 5'd12, 5'd4);
        cyc(0, 1, 5'd11, 32'h11, 0, 0, 1, 1, 5'd6, 32'hBEEF, 5'd12, 5'd4);
        cyc(0, 1, 5'd11, 32'h12, 0, 0, 0, 0, 0, 0, 5'd12, 5'd4);
        cyc(1, 1, 5'd11, 32'h13, 0, 0, 0, 0, 0, 0, 5'd12, 5'd4);
        idle(5'd12, 5'd4);
        idle(5'd6, 5'd5);
        idle(5'd11, 5'd3);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom % 300) == 0, ($urandom % 10) < 7, 5'($urandom % 8), $urandom,
                ($urandom % 4) == 0, 5'($urandom % 8),
                ($urandom % 5) == 0, 1'($urandom % 2), 5'($urandom % 8), $urandom,
                5'($urandom % 8), 5'($urandom % 8));
        end

        // Drain pending debug responses within a bounded number of cycles
        n = 0;
        while ((dbg_q.size() != 0 || phase != 0) && n < 20) begin
            idle(5'd1, 5'd2);
            n++;
        end
        chk("drain_pending", 32'(dbg_q.size()), 32'd0);
        idle(5'd1, 5'd2);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the core general-purpose register file.
- Provides NUM_RD combinational read ports with write-through bypass and one core write port.
- Adds a per-register busy scoreboard, set at issue and cleared at writeback, so ID can detect RAW hazards on in-flight loads and multi-cycle results.
- Adds an arbitrated debug (JTAG) access port with a request/response handshake and a starvation guard; it sits between ID, EX/WB and the JTAG DM.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; depth = 2**ADDR_W, register 0 hardwired to zero
NUM_RD, 2, number of read ports (1..4)
DBG_STARVE, 4, consecutive blocked cycles after which a debug access preempts the core write

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
raddr_i  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
rdata_o  out  NUM_RD*DATA_W  read data per port
rbusy_o  out  NUM_RD  scoreboard busy bit for each read address
we_i  in  1  core write enable
waddr_i  in  ADDR_W  core write address
wdata_i  in  DATA_W  core write data
issue_i  in  1  instruction with destination issued; mark destination busy
issue_addr_i  in  ADDR_W  destination of the issued instruction
wr_stall_o  out  1  core write this cycle is dropped and must be held by the core
dbg_req_i  in  1  debug access request (sampled only in IDLE)
dbg_we_i  in  1  1 = write, 0 = read
dbg_addr_i  in  ADDR_W  debug address
dbg_wdata_i  in  DATA_W  debug write data
dbg_busy_o  out  1  debug FSM not IDLE
dbg_valid_o  out  1  one-cycle completion pulse
dbg_rdata_o  out  DATA_W  debug read data, valid with dbg_valid_o

Behaviour:
Reset:
- rst high clears all registers, all busy bits, the FSM (to IDLE) and the starvation counter.
- Reset values: dbg_valid_o=0, dbg_rdata_o=0, dbg_busy_o=0, wr_stall_o=0.
- While rst is high, rdata_o=0 and rbusy_o=0.
- Reset mid-access aborts the access with no response.

Read ports (combinational, per port k):
- Address 0 returns 0 with busy 0.
- Else if we_i=1, wr_stall_o=0 and waddr_i matches: return wdata_i (bypass).
- Else return the stored value.
- rbusy_o[k] is the registered busy bit; it is not bypassed.

Core write:
- Writes at the clock edge when we_i=1, waddr_i!=0 and wr_stall_o=0.
- Writes to address 0 are ignored.

Scoreboard:
- A core write clears busy[waddr_i].
- issue_i sets busy[issue_addr_i].
- If the set and clear target the same register in the same cycle, set wins.
- Address 0 is never busy.
- A dropped (stalled) write does not clear busy.

Debug FSM, states IDLE, ARB, RESP:
- IDLE: when dbg_req_i=1, latch we/addr/wdata, clear the counter, go to ARB.
- ARB, we_i=0: perform the access at the edge and go to RESP.
  - Read captures the stored value into dbg_rdata_o.
  - Write updates the register (address 0 ignored; busy bits untouched).
- ARB, we_i=1 and counter < DBG_STARVE: increment the counter and stay in ARB.
- ARB, we_i=1 and counter == DBG_STARVE: assert wr_stall_o combinationally, perform the debug access, go to RESP.
- RESP: dbg_valid_o=1 for exactly one cycle, then return to IDLE.
- Debug read latency: minimum 2 cycles from request to dbg_valid_o; maximum DBG_STARVE+2.
- dbg_busy_o = (state != IDLE). dbg_req_i is ignored outside IDLE.
- wr_stall_o is asserted only in the preemption cycle.

Test Plan:
- Write x5=0x1234_5678, then read it on both ports the next cycle -> both rdata=0x1234_5678. Read x0 after a write of x0=0xFFFF_FFFF -> 0.
- Bypass: we_i=1, waddr=7, wdata=0xA5A5_A5A5, raddr0=7 in the same cycle -> rdata0=0xA5A5_A5A5 in that cycle.
- Scoreboard: issue x9 -> rbusy=1 from the next cycle. Core write x9 together with issue x9 in the same cycle -> busy stays 1. Plain write x9 later -> busy 0.
- Debug read of x3=0x55 with core idle -> dbg_valid_o pulses 2 cycles after the request with dbg_rdata_o=0x55.
- Starvation: we_i held 1 continuously (DBG_STARVE=4), debug write x4=0xDEAD -> wr_stall_o high in the 5th ARB cycle only. Core write in that cycle is dropped; x4=0xDEAD; dbg_valid_o pulses the next cycle.
- Assert rst during ARB -> dbg_busy_o=0, no dbg_valid_o, all registers and busy bits read 0 after release.
